ddr_wr_row_master: RTL and testbench

- Write-side master feeding one write channel (m1..m4) of the DDR write arbiter.
- Buffers 256-bit packed pixel words, already in the ddr_clk domain, in a FWFT FIFO.
- Issues one row-sized burst write request per video row and walks row addresses through a ping-pong pair of frame buffers.
- Reports frame completion and the last completed buffer to the downstream read side.

---
 rtl/ddr_wr_row_master_if.sv | 31 +++
 rtl/ddr_wr_row_master.sv | 186 ++++++++++++++++++
 tb/tb_ddr_wr_row_master.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr_wr_row_master_if.sv
// ddr_wr_row_master_if
// Write-channel bundle between a row master and the DDR write arbiter.
//   m_wr_req        master -> arbiter  burst write request
//   m_wr_addr       master -> arbiter  burst start address (DQ beat units)
//   m_wr_len        master -> arbiter  burst length in 256-bit words
//   m_wr_data       master -> arbiter  FIFO head word
//   m_ddr_wrdy      arbiter -> master  command accepted
//   m_ddr_wdone     arbiter -> master  burst complete
//   m_ddr_wdata_req arbiter -> master  data pop strobe
interface ddr_wr_row_master_if #(
    parameter int DDR_ADDR_WIDTH = 28,
    parameter int DQ_WIDTH       = 32
);
    logic                      m_wr_req;
    logic [DDR_ADDR_WIDTH-1:0] m_wr_addr;
    logic [31:0]               m_wr_len;
    logic [8*DQ_WIDTH-1:0]     m_wr_data;
    logic                      m_ddr_wrdy;
    logic                      m_ddr_wdone;
    logic                      m_ddr_wdata_req;

    modport master (
        output m_wr_req, m_wr_addr, m_wr_len, m_wr_data,
        input  m_ddr_wrdy, m_ddr_wdone, m_ddr_wdata_req
    );

    modport slave (
        input  m_wr_req, m_wr_addr, m_wr_len, m_wr_data,
        output m_ddr_wrdy, m_ddr_wdone, m_ddr_wdata_req
    );
endinterface

// File: rtl/ddr_wr_row_master.sv
// ddr_wr_row_master
// Buffers packed 256-bit pixel words in a first-word-fall-through FIFO and
// issues one row-sized burst write per video row, walking row addresses
// through a ping-pong pair of frame buffers.
//
// Ports:
//   ddr_clk, rstn      clock, async active-low reset
//   vs_in              frame-start pulse (restarts row walk in the active buffer)
//   din_valid/din      input words; din_ready = FIFO not full
//   m                  write channel to the arbiter (master modport)
//   frame_done         one-cycle pulse when the last row of a frame completes
//   rd_buf_sel         last fully written buffer
//   err_flags          sticky: [0] overflow, [1] underflow, [2] short burst
//
// FSM states:
//   state | meaning
//   IDLE  | waiting for a full row of words in the FIFO
//   REQ   | m_wr_req held with a stable address until m_ddr_wrdy
//   DATA  | burst in flight, counting pops until m_ddr_wdone
//   DONE  | one cycle: advance row / swap buffer / apply latched vs_in
module ddr_wr_row_master #(
    parameter int                        DDR_ADDR_WIDTH = 28,
    parameter int                        DQ_WIDTH       = 32,
    parameter int                        V_NUM          = 360,
    parameter int                        ROW_WORDS      = 40,
    parameter int                        FIFO_AW        = 7,
    parameter logic [DDR_ADDR_WIDTH-1:0] BUF0_BASE      = 28'h0000000,
    parameter logic [DDR_ADDR_WIDTH-1:0] BUF1_BASE      = 28'h0100000
) (
    input  logic                    ddr_clk,
    input  logic                    rstn,
    input  logic                    vs_in,
    input  logic                    din_valid,
    input  logic [8*DQ_WIDTH-1:0]   din,
    output logic                    din_ready,
    ddr_wr_row_master_if.master     m,
    output logic                    frame_done,
    output logic                    rd_buf_sel,
    output logic [2:0]              err_flags
);

    localparam int W     = 8 * DQ_WIDTH;
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int RW    = (V_NUM > 1) ? $clog2(V_NUM) : 1;
    localparam int BW    = $clog2(ROW_WORDS + 1);

    localparam logic [FIFO_AW:0]        FULL_CNT   = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0]        ROW_CNT    = (FIFO_AW + 1)'(ROW_WORDS);
    localparam logic [BW-1:0]           ROW_BC     = BW'(ROW_WORDS);
    localparam logic [RW-1:0]           LAST_ROW   = RW'(V_NUM - 1);
    localparam logic [DDR_ADDR_WIDTH-1:0] ROW_STRIDE = DDR_ADDR_WIDTH'(ROW_WORDS * 8);

    typedef enum logic [1:0] {IDLE, REQ, DATA, DONE} state_t;

    // ---------------- FIFO ----------------
    logic [W-1:0]       mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   count;
    logic               empty;
    logic               push;
    logic               pop;

    assign empty     = (count == '0);
    assign din_ready = (count != FULL_CNT);
    assign push      = din_valid && din_ready;
    assign pop       = m.m_ddr_wdata_req && !empty;

    assign m.m_wr_data = empty ? '0 : mem[rd_ptr];
    assign m.m_wr_len  = 32'(ROW_WORDS);

    // Storage needs no reset: the head is masked to zero while empty.
    always_ff @(posedge ddr_clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge ddr_clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ---------------- row sequencer ----------------
    state_t          state;
    logic [RW-1:0]   row;
    logic [BW-1:0]   burst_cnt;
    logic [BW-1:0]   burst_next;
    logic            act_buf;
    logic            vs_pend;

    function automatic logic [DDR_ADDR_WIDTH-1:0] base_addr(input logic sel);
        return sel ? BUF1_BASE : BUF0_BASE;
    endfunction

    // Saturating so a runaway pop stream can never wrap back onto ROW_WORDS.
    always_comb begin
        burst_next = burst_cnt;
        if (pop && (burst_cnt != '1)) begin
            burst_next = burst_cnt + 1'b1;
        end
    end

    always_ff @(posedge ddr_clk or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            row          <= '0;
            burst_cnt    <= '0;
            act_buf      <= 1'b0;
            vs_pend      <= 1'b0;
            m.m_wr_req   <= 1'b0;
            m.m_wr_addr  <= BUF0_BASE;
            frame_done   <= 1'b0;
            rd_buf_sel   <= 1'b1;
            err_flags    <= '0;
        end else begin
            frame_done <= 1'b0;
            if (din_valid && !din_ready)       err_flags[0] <= 1'b1;
            if (m.m_ddr_wdata_req && empty)    err_flags[1] <= 1'b1;

            case (state)
                IDLE: begin
                    if (vs_in) begin
                        row         <= '0;
                        m.m_wr_addr <= base_addr(act_buf);
                    end
                    if (count >= ROW_CNT) begin
                        state      <= REQ;
                        m.m_wr_req <= 1'b1;
                        burst_cnt  <= '0;
                    end
                end

                REQ: begin
                    if (vs_in) vs_pend <= 1'b1;
                    if (m.m_ddr_wrdy) begin
                        m.m_wr_req <= 1'b0;
                        state      <= DATA;
                    end
                end

                DATA: begin
                    if (vs_in) vs_pend <= 1'b1;
                    burst_cnt <= burst_next;
                    // A pop coincident with wdone still belongs to this burst.
                    if (m.m_ddr_wdone) begin
                        if (burst_next != ROW_BC) err_flags[2] <= 1'b1;
                        state <= DONE;
                    end
                end

                DONE: begin
                    if (vs_pend || vs_in) begin
                        row         <= '0;
                        m.m_wr_addr <= base_addr(act_buf);
                    end else if (row == LAST_ROW) begin
                        row         <= '0;
                        act_buf     <= ~act_buf;
                        m.m_wr_addr <= base_addr(~act_buf);
                        rd_buf_sel  <= act_buf;
                        frame_done  <= 1'b1;
                    end else begin
                        row         <= row + 1'b1;
                        m.m_wr_addr <= m.m_wr_addr + ROW_STRIDE;
                    end
                    vs_pend <= 1'b0;
                    state   <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_wr_row_master.sv
// Testbench for ddr_wr_row_master: random pixel feed, a bus-functional
// arbiter, and a scoreboard monitor that checks FIFO data order, request
// addresses, frame completion and sticky error flags against a
// frame/row-level reference model.
module tb_ddr_wr_row_master;

    localparam int          AW    = 28;
    localparam int          DQ    = 32;
    localparam int          W     = 8 * DQ;
    localparam int          VN    = 360;
    localparam int          RW    = 40;
    localparam int          DEPTH = 128;
    localparam logic [AW-1:0] BUF0 = 28'h0000000;
    localparam logic [AW-1:0] BUF1 = 28'h0100000;

    logic          ddr_clk = 1'b0;
    logic          rstn = 1'b0;
    logic          vs_in = 1'b0;
    logic          din_valid = 1'b0;
    logic [W-1:0]  din = '0;
    logic          din_ready;
    logic          frame_done;
    logic          rd_buf_sel;
    logic [2:0]    err_flags;

    ddr_wr_row_master_if #(.DDR_ADDR_WIDTH(AW), .DQ_WIDTH(DQ)) bus ();

    ddr_wr_row_master #(
        .DDR_ADDR_WIDTH(AW), .DQ_WIDTH(DQ), .V_NUM(VN), .ROW_WORDS(RW),
        .FIFO_AW(7), .BUF0_BASE(BUF0), .BUF1_BASE(BUF1)
    ) dut (
        .ddr_clk    (ddr_clk),
        .rstn       (rstn),
        .vs_in      (vs_in),
        .din_valid  (din_valid),
        .din        (din),
        .din_ready  (din_ready),
        .m          (bus),
        .frame_done (frame_done),
        .rd_buf_sel (rd_buf_sel),
        .err_flags  (err_flags)
    );

    always #5 ddr_clk = ~ddr_clk;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [W-1:0]  mq[$];
    logic [AW-1:0] exp_addr_q[$];
    logic          exp_frame_q[$];
    logic [2:0]    exp_err;
    logic          exp_rd_sel;
    int            m_row;
    logic          m_act;
    int            frames_seen;
    int            frames_exp;
    logic          feed_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] w;
        for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    function automatic logic [AW-1:0] row_addr(input logic act, input int row);
        return (act ? BUF1 : BUF0) + AW'(row * RW * 8);
    endfunction

    // ---------------- scoreboard monitor ----------------
    logic req_prev = 1'b0;
    int   bpops = 0;

    always @(negedge ddr_clk) begin
        int sz0;
        logic [AW-1:0] ea;
        if (!rstn) begin
            req_prev = 1'b0;
            bpops    = 0;
        end else begin
            sz0 = mq.size();
            chk("din_ready", 64'(din_ready), 64'(sz0 != DEPTH));
            chk("err_flags", 64'(err_flags), 64'(exp_err));

            if (bus.m_wr_req && !req_prev) begin
                if (exp_addr_q.size() == 0) begin
                    chk("unexpected_req", 64'(1), 64'(0));
                end else begin
                    ea = exp_addr_q.pop_front();
                    chk("req_addr", 64'(bus.m_wr_addr), 64'(ea));
                    chk("req_len", 64'(bus.m_wr_len), 64'(RW));
                    chk("req_fill", 64'(sz0 >= RW), 64'(1));
                end
            end
            req_prev = bus.m_wr_req;

            if (frame_done) begin
                frames_seen++;
                if (exp_frame_q.size() == 0) chk("unexpected_frame_done", 64'(1), 64'(0));
                else exp_rd_sel = exp_frame_q.pop_front();
            end
            chk("rd_buf_sel", 64'(rd_buf_sel), 64'(exp_rd_sel));

            if (bus.m_ddr_wrdy) bpops = 0;
            if (bus.m_ddr_wdata_req) begin
                if (sz0 > 0) begin
                    checks++;
                    if (bus.m_wr_data !== mq[0]) begin
                        errors++;
                        $display("FAIL wr_data: got %h expected %h", bus.m_wr_data, mq[0]);
                    end
                    void'(mq.pop_front());
                    bpops++;
                end else begin
                    exp_err[1] = 1'b1;
                end
            end else if (sz0 == 0) begin
                chk("empty_data_zero", 64'(bus.m_wr_data != '0), 64'(0));
            end
            if (bus.m_ddr_wdone && bpops != RW) exp_err[2] = 1'b1;

            if (din_valid) begin
                if (sz0 != DEPTH) mq.push_back(din);
                else exp_err[0] = 1'b1;
            end
        end
    end

    // ---------------- random feeder ----------------
    initial begin
        forever begin
            @(posedge ddr_clk);
            #2;
            if (feed_en) begin
                if (din_ready && $urandom_range(7) != 0) begin
                    din_valid = 1'b1;
                    din       = rand_word();
                end else begin
                    din_valid = 1'b0;
                end
            end
        end
    end

    // ---------------- stimulus / arbiter ----------------
    task automatic do_reset();
        feed_en = 1'b0;
        din_valid = 1'b0;
        vs_in = 1'b0;
        bus.m_ddr_wrdy = 1'b0;
        bus.m_ddr_wdone = 1'b0;
        bus.m_ddr_wdata_req = 1'b0;
        rstn = 1'b0;
        mq.delete();
        exp_addr_q.delete();
        exp_addr_q.push_back(BUF0);
        exp_frame_q.delete();
        exp_err = '0;
        exp_rd_sel = 1'b1;
        m_row = 0;
        m_act = 1'b0;
        repeat (3) begin
            @(negedge ddr_clk);
            chk("rst_req", 64'(bus.m_wr_req), 64'(0));
            chk("rst_addr", 64'(bus.m_wr_addr), 64'(BUF0));
            chk("rst_len", 64'(bus.m_wr_len), 64'(RW));
            chk("rst_frame_done", 64'(frame_done), 64'(0));
            chk("rst_rd_buf_sel", 64'(rd_buf_sel), 64'(1));
            chk("rst_err", 64'(err_flags), 64'(0));
            chk("rst_din_ready", 64'(din_ready), 64'(1));
            chk("rst_data_zero", 64'(bus.m_wr_data != '0), 64'(0));
        end
        @(posedge ddr_clk);
        #1 rstn = 1'b1;
    endtask

    task automatic model_row_done(input logic vs);
        if (vs) begin
            m_row = 0;
        end else if (m_row == VN - 1) begin
            exp_frame_q.push_back(m_act);
            frames_exp++;
            m_act = ~m_act;
            m_row = 0;
        end else begin
            m_row++;
        end
        exp_addr_q.push_back(row_addr(m_act, m_row));
    endtask

    // One row burst: wait for the request, grant after a random delay,
    // pop npops words, then signal done. vs_at pulses vs_in at that pop;
    // rst_at asserts reset at that pop and abandons the burst.
    task automatic run_row(input int npops, input int vs_at, input int rst_at);
        int t;
        t = 0;
        while (!bus.m_wr_req && t < 3000) begin
            @(posedge ddr_clk);
            #1;
            t++;
        end
        if (!bus.m_wr_req) begin
            chk("req_wait_timeout", 64'(1), 64'(0));
            return;
        end
        repeat ($urandom_range(3)) begin
            @(posedge ddr_clk);
            #1;
        end
        chk("req_held", 64'(bus.m_wr_req), 64'(1));
        bus.m_ddr_wrdy = 1'b1;
        @(posedge ddr_clk);
        #1 bus.m_ddr_wrdy = 1'b0;
        for (int i = 0; i < npops; i++) begin
            if (i == rst_at) begin
                do_reset();
                return;
            end
            if ($urandom_range(7) == 0) begin
                @(posedge ddr_clk);
                #1;
            end
            bus.m_ddr_wdata_req = 1'b1;
            if (i == vs_at) vs_in = 1'b1;
            @(posedge ddr_clk);
            #1;
            bus.m_ddr_wdata_req = 1'b0;
            vs_in = 1'b0;
        end
        bus.m_ddr_wdone = 1'b1;
        @(posedge ddr_clk);
        #1 bus.m_ddr_wdone = 1'b0;
        model_row_done(vs_at >= 0);
    endtask

    initial begin
        #950000;
        $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
        $fatal(1, "watchdog timeout");
    end

    initial begin
        frames_seen = 0;
        frames_exp  = 0;
        do_reset();

        // overflow: 130 words, no pops
        for (int i = 0; i < 130; i++) begin
            din_valid = 1'b1;
            din = rand_word();
            @(posedge ddr_clk);
            #1;
        end
        din_valid = 1'b0;
        @(negedge ddr_clk);
        chk("ovf_din_ready_low", 64'(din_ready), 64'(0));
        chk("ovf_flag", 64'(err_flags[0]), 64'(1));
        @(posedge ddr_clk);
        #1 feed_en = 1'b1;

        run_row(RW, -1, -1);
        run_row(RW, -1, -1);
        run_row(RW - 1, -1, -1);     // short burst, row still advances
        @(negedge ddr_clk);
        chk("short_burst_flag", 64'(err_flags[2]), 64'(1));
        run_row(RW, -1, -1);
        run_row(RW, -1, -1);
        run_row(RW, 17, -1);         // vs_in mid-DATA at row 5

        for (int r = 0; r < VN; r++) run_row(RW, -1, -1);
        repeat (4) @(negedge ddr_clk);
        chk("frame1_rd_buf_sel", 64'(rd_buf_sel), 64'(0));
        for (int r = 0; r < VN; r++) run_row(RW, -1, -1);
        repeat (4) @(negedge ddr_clk);
        chk("frame2_rd_buf_sel", 64'(rd_buf_sel), 64'(1));
        chk("frames_seen", 64'(frames_seen), 64'(frames_exp));

        run_row(RW, -1, 10);         // reset mid-burst
        feed_en = 1'b1;
        run_row(RW, -1, -1);
        run_row(RW, -1, -1);

        @(posedge ddr_clk);
        #1 feed_en = 1'b0;
        din_valid = 1'b0;
        repeat (5) @(negedge ddr_clk);
        chk("frame_queue_drained", 64'(exp_frame_q.size()), 64'(0));
        chk("frames_total", 64'(frames_seen), 64'(2));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
